// File: rtl/demux_pkg.sv
// Shared definitions for the demux_router slice: channel geometry,
// flush FSM state type and the drop counter width.
package demux_pkg;

    localparam int NUM_CH     = 31;
    localparam int DW         = 2;
    localparam int SELW       = 5;
    localparam int DROP_CNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel.
// Priority: clear (flush sweep) over fill over drain. A simultaneous
// fill and drain leaves the slot full with the new data.
module demux_slot
    import demux_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fill,
    input  logic          drain,
    input  logic          clear,
    input  logic [DW-1:0] fill_data,
    output logic          valid,
    output logic [DW-1:0] data
);

    // Slot occupancy and payload; data is kept after a drain, zeroed by clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (fill) begin
            valid <= 1'b1;
            data  <= fill_data;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_router.sv
// Routes one DW-bit input stream to one of NUM_CH channel slots chosen by
// in_sel. Out-of-range selects are accepted and discarded (drop_err pulse).
// A flush pulse starts a sweep that clears one slot per cycle.
// Optional feature macro: DEMUX_DROP_CNT_EN adds a saturating drop_cnt port.
//
// Handshake: a beat moves when valid and ready are both high on a rising
// edge. in_ready is combinational from the slot state and out_ready, so a
// full slot that drains this cycle can take a new beat (pass-through).
module demux_router
    import demux_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [SELW-1:0]      in_sel,
    input  logic [DW-1:0]        in_data,
    output logic                 in_ready,
    output logic [NUM_CH*DW-1:0] out_data,
    output logic [NUM_CH-1:0]    out_valid,
    input  logic [NUM_CH-1:0]    out_ready,
    input  logic                 flush,
    output logic                 busy,
    output logic                 drop_err
`ifdef DEMUX_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    state_t            state;
    logic [SELW-1:0]   idx;
    logic              sel_in_range;
    logic              slot_free;
    logic              accept;
    logic [NUM_CH-1:0] fill_vec;
    logic [NUM_CH-1:0] drain_vec;
    logic [NUM_CH-1:0] clear_vec;

    // Select decode, in_ready and per-slot fill/drain/clear strobes.
    always_comb begin
        sel_in_range = (in_sel < SELW'(NUM_CH));
        slot_free    = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (in_sel == SELW'(k)) begin
                slot_free = !out_valid[k] || out_ready[k];
            end
        end
        in_ready = rst_n && (state == IDLE) && slot_free;
        accept   = in_valid && in_ready;
        for (int k = 0; k < NUM_CH; k++) begin
            fill_vec[k]  = accept && (in_sel == SELW'(k));
            drain_vec[k] = (state == IDLE) && out_valid[k] && out_ready[k];
            clear_vec[k] = (state == FLUSH) && (idx == SELW'(k));
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_slot
            demux_slot u_slot (
                .clk       (clk),
                .rst_n     (rst_n),
                .fill      (fill_vec[g]),
                .drain     (drain_vec[g]),
                .clear     (clear_vec[g]),
                .fill_data (in_data),
                .valid     (out_valid[g]),
                .data      (out_data[g*DW +: DW])
            );
        end
    endgenerate

    // Flush FSM with sweep index, registered busy and drop_err pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            busy     <= 1'b0;
            drop_err <= 1'b0;
        end else begin
            drop_err <= accept && !sel_in_range;
            case (state)
                IDLE: begin
                    if (flush) begin
                        state <= FLUSH;
                        busy  <= 1'b1;
                        idx   <= '0;
                    end
                end
                FLUSH: begin
                    if (idx == SELW'(NUM_CH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    idx   <= '0;
                end
            endcase
        end
    end

`ifdef DEMUX_DROP_CNT_EN
    // Saturating count of discarded beats; untouched by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop_err && (drop_cnt != {DROP_CNT_W{1'b1}})) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`else
    // No drop counter in this build; drop_err still reports each discard.
`endif

endmodule

// File: tb/tb_demux_router.sv
// Self-checking bench for demux_router: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the channel slots.
module tb_demux_router;
    import demux_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic [SELW-1:0]      in_sel;
    logic [DW-1:0]        in_data;
    logic                 in_ready;
    logic [NUM_CH*DW-1:0] out_data;
    logic [NUM_CH-1:0]    out_valid;
    logic [NUM_CH-1:0]    out_ready;
    logic                 flush;
    logic                 busy;
    logic                 drop_err;
`ifdef DEMUX_DROP_CNT_EN
    logic [7:0]           drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    demux_router dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .busy      (busy),
        .drop_err  (drop_err)
`ifdef DEMUX_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit       m_valid [NUM_CH];
    bit [1:0] m_data  [NUM_CH];
    int       m_flush_left = 0;   // cycles of sweep still to run; 0 = not flushing
    bit       m_drop = 0;
    int       m_cnt = 0;

    function automatic bit model_ready();
        if (!rst_n || m_flush_left != 0) return 1'b0;
        if (int'(in_sel) >= NUM_CH) return 1'b1;
        return !m_valid[in_sel] || out_ready[in_sel];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                m_valid[k] = 0;
                m_data[k]  = 0;
            end
            m_flush_left = 0;
            m_drop       = 0;
            m_cnt        = 0;
        end else begin
            bit rdy;
            rdy = model_ready();
            if (m_drop && m_cnt < 255) m_cnt++;
            m_drop = in_valid && rdy && (int'(in_sel) >= NUM_CH);
            if (m_flush_left != 0) begin
                m_valid[NUM_CH - m_flush_left] = 0;
                m_data[NUM_CH - m_flush_left]  = 0;
                m_flush_left--;
            end else begin
                for (int k = 0; k < NUM_CH; k++)
                    if (m_valid[k] && out_ready[k]) m_valid[k] = 0;
                if (in_valid && rdy && int'(in_sel) < NUM_CH) begin
                    m_valid[in_sel] = 1;
                    m_data[in_sel]  = in_data;
                end
                if (flush) m_flush_left = NUM_CH;
            end
        end
    end

    // per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        logic [NUM_CH-1:0]    ev;
        logic [NUM_CH*DW-1:0] ed;
        for (int k = 0; k < NUM_CH; k++) begin
            ev[k]            = m_valid[k];
            ed[k*DW +: DW]   = m_data[k];
        end
        check("cyc_out_valid", 64'(out_valid), 64'(ev));
        check("cyc_out_data",  64'(out_data),  64'(ed));
        check("cyc_in_ready",  64'(in_ready),  64'(model_ready()));
        check("cyc_busy",      64'(busy),      64'(m_flush_left != 0));
        check("cyc_drop_err",  64'(drop_err),  64'(m_drop));
`ifdef DEMUX_DROP_CNT_EN
        check("cyc_drop_cnt",  64'(drop_cnt),  64'(m_cnt));
`endif
    end

    // ---------------- driver helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int sel, input int data);
        in_valid = 1'b1;
        in_sel   = SELW'(sel);
        in_data  = DW'(data);
    endtask

    int busy_cycles;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 5'd3;
        in_data   = 2'b00;
        out_ready = '0;
        flush     = 1'b0;
        repeat (2) next_cycle();
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_data",  64'(out_data),  64'h0);
        check("rst_busy",      64'(busy),      64'h0);
        check("rst_in_ready",  64'(in_ready),  64'h0);
        next_cycle();
        rst_n = 1'b1;

        // 1: fill slot 3, then a second beat to the full slot stalls
        beat(3, 2);
        @(negedge clk);
        check("t1_in_ready", 64'(in_ready), 64'h1);
        next_cycle();
        beat(3, 1);
        @(negedge clk);
        check("t1_valid3", 64'(out_valid[3]), 64'h1);
        check("t1_data3",  64'(out_data[7:6]), 64'h2);
        check("t1_stall",  64'(in_ready), 64'h0);

        // 2: pass-through while slot 3 drains
        next_cycle();
        out_ready[3] = 1'b1;
        @(negedge clk);
        check("t2_in_ready", 64'(in_ready), 64'h1);
        next_cycle();
        in_valid  = 1'b0;
        out_ready = '0;
        @(negedge clk);
        check("t2_valid3", 64'(out_valid[3]), 64'h1);
        check("t2_data3",  64'(out_data[7:6]), 64'h1);

        // 3: out-of-range beat is dropped
        next_cycle();
        beat(31, 3);
        @(negedge clk);
        check("t3_in_ready", 64'(in_ready), 64'h1);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check("t3_drop_err",  64'(drop_err), 64'h1);
        check("t3_out_valid", 64'(out_valid), 64'h8);
        next_cycle();
        @(negedge clk);
        check("t3_drop_gone", 64'(drop_err), 64'h0);
`ifdef DEMUX_DROP_CNT_EN
        check("t3_drop_cnt", 64'(drop_cnt), 64'h1);
`endif

        // 4: fill 0, 15, 30 then flush; a second flush mid-sweep is ignored
        next_cycle(); beat(0, 1);
        next_cycle(); beat(15, 2);
        next_cycle(); beat(30, 3);
        next_cycle(); in_valid = 1'b0;
        @(negedge clk);
        check("t4_filled", 64'(out_valid), 64'h4000_8009);
        next_cycle();
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        beat(5, 1);
        busy_cycles = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cycles++;
            check("t4_in_ready_flush", 64'(in_ready), 64'h0);
            next_cycle();
            flush = (busy_cycles == 5);
        end
        flush = 1'b0;
        check("t4_busy_cycles", 64'(busy_cycles), 64'd31);
        check("t4_all_clear",   64'(out_valid), 64'h0);
        check("t4_data_clear",  64'(out_data),  64'h0);
        next_cycle();
        in_valid = 1'b0;

        // 5: reset in the middle of a sweep
        next_cycle(); beat(7, 2);
        next_cycle(); in_valid = 1'b0; flush = 1'b1;
        next_cycle(); flush = 1'b0;
        repeat (10) next_cycle();
        @(negedge clk);
        check("t5_busy_before", 64'(busy), 64'h1);
        next_cycle();
        #1;
        rst_n = 1'b0;
        beat(2, 3);
        @(negedge clk);
        check("t5_rst_valid", 64'(out_valid), 64'h0);
        check("t5_rst_busy",  64'(busy),      64'h0);
        check("t5_rst_ready", 64'(in_ready),  64'h0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_ready_after", 64'(in_ready), 64'h1);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check("t5_routed", 64'(out_valid), 64'h4);
        check("t5_data2",  64'(out_data[5:4]), 64'h3);

        // 6: long run of out-of-range beats
        next_cycle();
        for (int i = 0; i < 300; i++) begin
            beat(31, i);
            next_cycle();
        end
        in_valid = 1'b0;
        repeat (2) next_cycle();
`ifdef DEMUX_DROP_CNT_EN
        @(negedge clk);
        check("t6_drop_sat", 64'(drop_cnt), 64'd255);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = SELW'($urandom_range(0, 31));
            in_data   = DW'($urandom);
            out_ready = NUM_CH'($urandom);
            flush     = ($urandom_range(0, 99) == 0);
            next_cycle();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        repeat (3) next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
